// File: rtl/multicycle_controller.sv
// Moore-style control FSM that sequences a shared multicycle MIPS datapath.
// Each state drives every datapath mux select and write enable for one cycle.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       immext,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next     = S_FETCH;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        immext     = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                irwrite = 1'b1;
                pcen    = 1'b1;
                alusrcb = 2'b01;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:                      w_next = S_MEMADR;
                    OP_RTYPE:                          w_next = S_EXECUTE;
                    OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEXEC;
                    OP_J:                              w_next = S_JUMP;
                    OP_JAL:                            w_next = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 2'b01;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alucontrol = ALU_ADD;
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 2'b01;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                if (op == OP_BEQ) begin
                    pcen = zero;
                end else if (op == OP_BNE) begin
                    pcen = ~zero;
                end
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin alucontrol = ALU_AND; immext = 1'b1; end
                    OP_ORI:  begin alucontrol = ALU_OR;  immext = 1'b1; end
                    OP_SLTI: alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
                w_next = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4, so the link value and the jump share one edge
                regdst   = 2'b10;
                memtoreg = 2'b10;
                regwrite = 1'b1;
                pcsrc    = 2'b10;
                pcen     = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        if (reset) begin
            irwrite  = 1'b0;
            pcen     = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: walks each instruction class
// through its state sequence and checks the control outputs per state.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, pcen, regwrite, alusrca, immext, illegal;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checkCount = 0;
    int failCount  = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .immext     (immext),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] newOp, input logic [5:0] newFunct, input logic newZero);
        op    = newOp;
        funct = newFunct;
        zero  = newZero;
    endtask

    // Advance one clock and settle 1 time unit past the edge before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(6'b000000, 6'b000000, 1'b0);
        tick();
        tick();
        checkOutput("rst_state", {28'd0, state}, 32'd0);
        checkOutput("rst_irwrite", {31'd0, irwrite}, 32'd0);
        checkOutput("rst_pcen", {31'd0, pcen}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_irwrite", {31'd0, irwrite}, 32'd1);
        checkOutput("post_rst_pcen", {31'd0, pcen}, 32'd1);

        // LW interrupted by reset in MEMRD
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("lwint_state3", {28'd0, state}, 32'd3);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midrst_state", {28'd0, state}, 32'd0);
            checkOutput("midrst_writes", {28'd0, irwrite, pcen, regwrite, memwrite}, 32'd0);
            checkOutput("midrst_illegal", {31'd0, illegal}, 32'd0);
        end
        reset = 1'b0;
        #1;
        checkOutput("rel_fetch_en", {30'd0, irwrite, pcen}, 32'h3);

        // LW full sequence 0,1,2,3,4,0
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        checkOutput("lw_s0_iord", {31'd0, iord}, 32'd0);
        tick();
        checkOutput("lw_state1", {28'd0, state}, 32'd1);
        tick();
        checkOutput("lw_state2", {28'd0, state}, 32'd2);
        checkOutput("lw_s2_iord", {31'd0, iord}, 32'd0);
        checkOutput("lw_s2_alusrc", {29'd0, alusrca, alusrcb}, 32'b110);
        tick();
        checkOutput("lw_state3", {28'd0, state}, 32'd3);
        checkOutput("lw_s3_iord", {31'd0, iord}, 32'd1);
        checkOutput("lw_s3_regwrite", {31'd0, regwrite}, 32'd0);
        tick();
        checkOutput("lw_state4", {28'd0, state}, 32'd4);
        checkOutput("lw_s4_wb", {29'd0, regwrite, memtoreg}, 32'b101);
        checkOutput("lw_s4_iord", {31'd0, iord}, 32'd0);
        tick();
        checkOutput("lw_back0", {28'd0, state}, 32'd0);

        // SW sequence 0,1,2,5,0
        applyStimulus(6'b101011, 6'b000000, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("sw_state5", {28'd0, state}, 32'd5);
        checkOutput("sw_s5_mem", {30'd0, iord, memwrite}, 32'b11);
        tick();
        checkOutput("sw_back0", {28'd0, state}, 32'd0);

        // BEQ taken with zero=1
        applyStimulus(6'b000100, 6'b000000, 1'b1);
        tick();
        checkOutput("beq_state1", {28'd0, state}, 32'd1);
        checkOutput("beq_s1_alusrcb", {30'd0, alusrcb}, 32'b11);
        tick();
        checkOutput("beq_state8", {28'd0, state}, 32'd8);
        checkOutput("beq_pcen", {31'd0, pcen}, 32'd1);
        checkOutput("beq_pcsrc", {30'd0, pcsrc}, 32'b01);
        checkOutput("beq_alu", {29'd0, alucontrol}, 32'b110);
        zero = 1'b0;
        #1;
        checkOutput("beq_nottaken_pcen", {31'd0, pcen}, 32'd0);
        tick();
        checkOutput("beq_back0", {28'd0, state}, 32'd0);

        // BNE with zero=1 is not taken
        applyStimulus(6'b000101, 6'b000000, 1'b1);
        tick();
        tick();
        checkOutput("bne_state8", {28'd0, state}, 32'd8);
        checkOutput("bne_pcen", {31'd0, pcen}, 32'd0);
        tick();
        checkOutput("bne_back0", {28'd0, state}, 32'd0);

        // ORI through IEXEC and IWB
        applyStimulus(6'b001101, 6'b000000, 1'b0);
        tick();
        tick();
        checkOutput("ori_state9", {28'd0, state}, 32'd9);
        checkOutput("ori_alu", {29'd0, alucontrol}, 32'b001);
        checkOutput("ori_immext", {31'd0, immext}, 32'd1);
        checkOutput("ori_alusrcb", {30'd0, alusrcb}, 32'b10);
        tick();
        checkOutput("ori_state10", {28'd0, state}, 32'd10);
        checkOutput("ori_wb", {29'd0, regwrite, regdst}, 32'b100);
        tick();
        checkOutput("ori_back0", {28'd0, state}, 32'd0);

        // SLTI uses slt with sign-extended immediate
        applyStimulus(6'b001010, 6'b000000, 1'b0);
        tick();
        tick();
        checkOutput("slti_alu_imm", {28'd0, alucontrol, immext}, 32'b1110);
        tick();
        tick();

        // JAL 0,1,12,0
        applyStimulus(6'b000011, 6'b000000, 1'b0);
        tick();
        tick();
        checkOutput("jal_state12", {28'd0, state}, 32'd12);
        checkOutput("jal_regdst", {30'd0, regdst}, 32'b10);
        checkOutput("jal_memtoreg", {30'd0, memtoreg}, 32'b10);
        checkOutput("jal_we", {30'd0, regwrite, pcen}, 32'b11);
        checkOutput("jal_pcsrc", {30'd0, pcsrc}, 32'b10);
        tick();
        checkOutput("jal_back0", {28'd0, state}, 32'd0);

        // Illegal opcode: one-cycle pulse in DECODE then back to FETCH
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        checkOutput("ill_s0_illegal", {31'd0, illegal}, 32'd0);
        tick();
        checkOutput("ill_state1", {28'd0, state}, 32'd1);
        checkOutput("ill_pulse", {31'd0, illegal}, 32'd1);
        checkOutput("ill_no_writes", {30'd0, regwrite, memwrite}, 32'd0);
        tick();
        checkOutput("ill_back0", {28'd0, state}, 32'd0);
        checkOutput("ill_cleared", {31'd0, illegal}, 32'd0);

        // RTYPE slt then sub
        applyStimulus(6'b000000, 6'b101010, 1'b0);
        tick();
        tick();
        checkOutput("rslt_state6", {28'd0, state}, 32'd6);
        checkOutput("rslt_alu", {29'd0, alucontrol}, 32'b111);
        funct = 6'b100010;
        #1;
        checkOutput("rsub_alu", {29'd0, alucontrol}, 32'b110);
        tick();
        checkOutput("r_state7", {28'd0, state}, 32'd7);
        checkOutput("r_wb", {29'd0, regwrite, regdst}, 32'b101);
        tick();
        checkOutput("r_back0", {28'd0, state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified instruction/data memory, IR, A/B, ALUOut and Data registers. Each instruction takes 2–5 cycles. It supports RTYPE (add/sub/and/or/slt), LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J and JAL. It sits beside the datapath and replaces single-cycle decode, driving every mux select and write enable once per state.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26], stable from end of FETCH until next FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from the current ALU operation
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write enable
- irwrite  out  1  IR load enable
- pcen  out  1  PC load enable: pcwrite | branch-taken
- regdst  out  2  write register select: 00 rt, 01 rd, 10 $31
- memtoreg  out  2  write data select: 00 ALUOut, 01 Data, 10 PC
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 B, 01 constant 4, 10 extended imm, 11 sign-imm<<2
- pcsrc  out  2  PC next select: 00 ALUResult, 01 ALUOut, 10 jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- immext  out  1  1 = zero-extend imm, 0 = sign-extend
- illegal  out  1  one-cycle pulse when an unsupported op is decoded
- state  out  4  current state, for debug and coverage

## Operation
- State register is 4 bits, and all outputs decode from state only. Exceptions are pcen in BRANCH, which uses zero and op, and alucontrol, immext and illegal, which use op and funct. Unlisted outputs are 0; alucontrol defaults to 010.
- FETCH (0): irwrite=1, pcen=1, alusrcb=01, add. Next state DECODE.
- DECODE (1): alusrcb=11, add, so the branch target lands in ALUOut. Next state by op:
  - 100011/101011 go to MEMADR.
  - 000000 goes to EXECUTE.
  - 000100/000101 go to BRANCH.
  - 001000/001100/001101/001010 go to IEXEC.
  - 000010 goes to JUMP.
  - 000011 goes to JAL.
  - Any other op sets illegal=1 and goes to FETCH. The instruction is skipped and PC has already advanced.
- MEMADR (2): alusrca=1, alusrcb=10, add. Next state MEMRD for LW, MEMWR for SW.
- MEMRD (3): iord=1. Next state MEMWB.
- MEMWB (4): regdst=00, memtoreg=01, regwrite=1. Next state FETCH.
- MEMWR (5): iord=1, memwrite=1. Next state FETCH.
- EXECUTE (6): alusrca=1, alusrcb=00. alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives 010. Next state ALUWB.
- ALUWB (7): regdst=01, regwrite=1. Next state FETCH.
- BRANCH (8): alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero for BEQ, ~zero for BNE. Next state FETCH.
- IEXEC (9): alusrca=1, alusrcb=10. ADDI gives add with immext=0. ANDI gives and with immext=1. ORI gives or with immext=1. SLTI gives slt with immext=0. Next state IWB.
- IWB (10): regdst=00, memtoreg=00, regwrite=1. Next state FETCH.
- JUMP (11): pcsrc=10, pcen=1. Next state FETCH.
- JAL (12): regdst=10, memtoreg=10 (PC already holds PC+4), regwrite=1, pcsrc=10, pcen=1. Next state FETCH.
- Encodings 13–15 drive default outputs and go to FETCH on the next edge.

## Timing
- Reset: at any clk edge with reset=1, state becomes FETCH (0). This holds mid-instruction; any partially executed instruction is abandoned.
- While reset=1, irwrite, pcen, memwrite, regwrite and illegal are forced to 0. The first FETCH with writes enabled is the first cycle after reset deasserts.
- Cycles per instruction, FETCH to FETCH:
  - LW 5
  - SW, RTYPE, I-type 4
  - BEQ, BNE, J, JAL 3
  - illegal 2
- State updates only on the rising clk edge.
- No handshakes: memory is assumed single-cycle; reads complete within the state that drives the address.
- Writes take effect at the clk edge ending their state:
  - regwrite in MEMWB/ALUWB/IWB/JAL
  - memwrite in MEMWR
  - irwrite and pcen in FETCH
- zero is sampled combinationally in BRANCH only. Glitches on zero in other states have no effect.
- JAL in one state: regwrite and pcen share the same edge. The register file captures the old PC (already PC+4) before PC updates.

## Test plan
- Reset held 3 cycles mid-MEMRD, then released -> state=0 during reset; no write enables asserted; irwrite=pcen=1 on the first post-reset cycle.
- LW (op=100011) -> state sequence 0,1,2,3,4,0. iord=1 only in state 3. regwrite=1 with memtoreg=01 only in state 4.
- BEQ with zero=1, then BNE with zero=1 -> sequence 0,1,8,0 in both cases. pcen=1 in state 8 for BEQ, pcen=0 in state 8 for BNE.
- ORI (op=001101) -> IEXEC gives alucontrol=001, immext=1, alusrcb=10; IWB gives regwrite=1, regdst=00.
- JAL (op=000011) -> sequence 0,1,12,0. In state 12: regdst=10, memtoreg=10, regwrite=1, pcen=1, pcsrc=10.
- op=111111 -> illegal=1 for exactly one cycle in state 1, then state 0. No regwrite/memwrite is issued. RTYPE funct=101010 gives alucontrol=111 in state 6.
